uart_transmitter: RTL and testbench

Serial transmit stage of the UART application: accepts bytes from the host over a strobe/ready handshake and drives them onto the serial line in the same 12-bit frame that the UART receive stage expects. Frame order is start (0), 8 data bits LSB first, parity slot, and 2 stop bits (1). It runs off the same 16x oversampling clock as the receive stage. A one-byte holding buffer in front of the shift register allows back-to-back frames with no idle gap.

---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_transmitter.sv | 145 ++++++++++++++
 tb/tb_uart_transmitter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Host-side write handshake of the UART transmitter: byte, one-cycle strobe,
// and the holding-buffer-empty Ready flag.
interface uart_tx_if;
  logic [7:0] DataIn;
  logic       WriteStrobe;
  logic       Ready;

  modport master (output DataIn, output WriteStrobe, input Ready);
  modport slave  (input DataIn, input WriteStrobe, output Ready);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit stage: 12-bit frame (start, 8 data LSB first, parity slot, 2 stop)
// fed from a one-byte holding buffer. Optional macro UART_TX_PARITY_EN selects
// even parity in the parity slot; when undefined the slot is driven 1.
module uart_transmitter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic      OverSampling,
  input  logic      Reset,
  uart_tx_if.slave  host,
  output logic      TxOut,
  output logic      Busy,
  output logic      Overrun
);

  localparam int TW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    idx_q;
  logic [7:0]    hold_q;
  logic [7:0]    shift_q;
  logic          ready_q;
  logic          tx_q;
  logic          busy_q;
  logic          ovr_q;
  logic          par_bit;

  logic bit_end;
  logic accept;
  logic reject;
  logic load;

  assign bit_end = (timer_q == TW'(OVERSAMPLE - 1));
  assign accept  = host.WriteStrobe &&  ready_q;
  assign reject  = host.WriteStrobe && !ready_q;
  // The shifter takes the held byte either from idle or at the very end of the
  // second stop bit, which is what makes back-to-back frames gapless.
  assign load    = !ready_q &&
                   ((state_q == IDLE) ||
                    (state_q == STOP && bit_end && idx_q[0]));

`ifdef UART_TX_PARITY_EN
  logic hold_par_q;
  logic par_q;
  assign par_bit = par_q;
`else
  assign par_bit = 1'b1;
`endif

  // NOTE: sequential state is assigned with <= only, so every register in this
  // block sees the pre-edge value of every other register regardless of order.
  always_ff @(posedge OverSampling or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      // NOTE: the data registers are reset along with control so that a
      // truncated frame leaves no stale byte behind.
      hold_q  <= '0;
      shift_q <= '0;
      ready_q <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      hold_par_q <= 1'b0;
      par_q      <= 1'b0;
`endif
    end else begin
      if (reject) ovr_q <= 1'b1;

      if (accept) begin
        hold_q  <= host.DataIn;
        ready_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
        hold_par_q <= ^host.DataIn;
`endif
      end

      if (state_q != IDLE) timer_q <= timer_q + 1'b1;

      unique case (state_q)
        IDLE: ;
        START: if (bit_end) begin
          state_q <= DATA;
          idx_q   <= '0;
          tx_q    <= shift_q[0];
        end
        DATA: if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_q <= PARITY;
            tx_q    <= par_bit;
          end else begin
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
            idx_q   <= idx_q + 3'd1;
          end
        end
        PARITY: if (bit_end) begin
          state_q <= STOP;
          idx_q   <= '0;
          tx_q    <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (!idx_q[0]) begin
            idx_q <= 3'd1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Placed last so a transfer overrides the STOP-end return to IDLE.
      if (load) begin
        shift_q <= hold_q;
        ready_q <= 1'b1;
        state_q <= START;
        timer_q <= '0;
        idx_q   <= '0;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
        par_q <= hold_par_q;
`endif
      end
    end
  end

  assign host.Ready = ready_q;
  assign TxOut      = tx_q;
  assign Busy       = busy_q;
  assign Overrun    = ovr_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame shape and timing, back-to-back,
// overrun, mid-frame reset and a mid-bit sampling receive model.
module tb_uart_transmitter;

  logic clk = 1'b0;
  logic rst_n;
  logic tx_out, busy, overrun;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_tx_if host_if ();

  uart_transmitter #(.OVERSAMPLE(16)) dut (
    .OverSampling (clk),
    .Reset        (rst_n),
    .host         (host_if),
    .TxOut        (tx_out),
    .Busy         (busy),
    .Overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic parity_slot(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return ^b;
`else
    return 1'b1;
`endif
  endfunction

  // Line bits LSB first: start, data[0..7], parity slot, stop, stop.
  function automatic logic [11:0] frame_bits(input logic [7:0] b);
    return {2'b11, parity_slot(b), b, 1'b0};
  endfunction

  // Returns at the negedge after the accepting posedge (E0).
  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    host_if.DataIn      = b;
    host_if.WriteStrobe = 1'b1;
    @(negedge clk);
    host_if.WriteStrobe = 1'b0;
  endtask

  // Entered at the negedge right after the start edge E1; leaves 192 clocks later.
  task automatic frame_check(input string tag, input logic [7:0] b);
    logic [11:0] f;
    int busy_low;
    f = frame_bits(b);
    busy_low = 0;
    for (int k = 0; k < 12; k++) begin
      int bad;
      bad = 0;
      for (int s = 0; s < 16; s++) begin
        if (tx_out !== f[k]) bad++;
        if (busy !== 1'b1) busy_low++;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d_bad_samples", tag, k), bad, 0);
    end
    check($sformatf("%s_busy_low_samples", tag), busy_low, 0);
  endtask

  // Receive-stage model: samples each bit in its middle.
  task automatic rx_model(output logic [7:0] data, output logic perr,
                          output logic start_ok, output logic stop_ok);
    logic [11:0] r;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      r[k] = tx_out;
      if (k < 11) repeat (16) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    data     = r[8:1];
    start_ok = (r[0] == 1'b0);
    stop_ok  = (r[11:10] == 2'b11);
`ifdef UART_TX_PARITY_EN
    perr = (r[9] != ^r[8:1]);
`else
    perr = (r[9] != 1'b1);
`endif
  endtask

  task automatic single_frame(input string tag, input logic [7:0] b);
    write_byte(b);
    @(negedge clk);
    frame_check(tag, b);
    check({tag, "_idle_tx"}, tx_out, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] rx_data;
    logic       rx_perr, rx_start, rx_stop;
    logic [7:0] lb [3] = '{8'h00, 8'h55, 8'hFF};

    rst_n               = 1'b0;
    host_if.DataIn      = '0;
    host_if.WriteStrobe = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", host_if.Ready, 1'b1);
    check("rst_tx", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tx", tx_out, 1'b1);

    // 0xA5: handshake timing around E0/E1, then the full frame.
    write_byte(8'hA5);
    check("a5_ready_after_e0", host_if.Ready, 1'b0);
    check("a5_tx_after_e0", tx_out, 1'b1);
    check("a5_busy_after_e0", busy, 1'b0);
    @(negedge clk);
    check("a5_ready_after_e1", host_if.Ready, 1'b1);
    frame_check("a5", 8'hA5);
    check("a5_idle_tx", tx_out, 1'b1);
    check("a5_idle_busy", busy, 1'b0);

    single_frame("b07", 8'h07);
    single_frame("b03", 8'h03);

    // Second byte written mid-frame: next start bit exactly at E1+192.
    write_byte(8'h01);
    @(negedge clk);
    fork
      frame_check("b2b_01", 8'h01);
      begin
        repeat (50) @(negedge clk);
        write_byte(8'h80);
      end
    join
    check("b2b_no_gap_tx", tx_out, 1'b0);
    frame_check("b2b_80", 8'h80);
    check("b2b_idle_busy", busy, 1'b0);
    check("b2b_overrun", overrun, 1'b0);

    // Three writes within one frame: third one is dropped.
    write_byte(8'h11);
    @(negedge clk);
    fork
      frame_check("ov_11", 8'h11);
      begin
        repeat (20) @(negedge clk);
        write_byte(8'h22);
        repeat (20) @(negedge clk);
        write_byte(8'h33);
      end
    join
    check("ov_flag_set", overrun, 1'b1);
    frame_check("ov_22", 8'h22);
    check("ov_idle_tx", tx_out, 1'b1);
    check("ov_idle_busy", busy, 1'b0);
    check("ov_ready", host_if.Ready, 1'b1);
    repeat (10) @(negedge clk);
    check("ov_flag_sticky", overrun, 1'b1);

    // Write on the same edge as the holding->shifter transfer.
    write_byte(8'h5A);
    host_if.DataIn      = 8'h66;
    host_if.WriteStrobe = 1'b1;
    @(negedge clk);
    host_if.WriteStrobe = 1'b0;
    check("sim_ready_after_xfer", host_if.Ready, 1'b1);
    frame_check("sim_5a", 8'h5A);
    check("sim_idle_busy", busy, 1'b0);
    check("sim_idle_tx", tx_out, 1'b1);

    // Asynchronous reset 70 clocks into a 0xFF frame.
    write_byte(8'hFF);
    @(negedge clk);
    repeat (70) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx_out, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", host_if.Ready, 1'b1);
    check("mid_rst_overrun", overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    single_frame("after_rst_3c", 8'h3C);

    // Loopback into the receive model.
    foreach (lb[i]) begin
      write_byte(lb[i]);
      @(negedge clk);
      rx_model(rx_data, rx_perr, rx_start, rx_stop);
      check($sformatf("lb%0d_data", i), rx_data, lb[i]);
      check($sformatf("lb%0d_perr", i), rx_perr, 1'b0);
      check($sformatf("lb%0d_start", i), rx_start, 1'b1);
      check($sformatf("lb%0d_stop", i), rx_stop, 1'b1);
      check($sformatf("lb%0d_idle_busy", i), busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
